// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode values, instruction field positions, bubble word.
package proc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 5;

  // Field bit positions within an instruction word
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RD_MSB = 26;
  localparam int unsigned RD_LSB = 22;
  localparam int unsigned RS_MSB = 21;
  localparam int unsigned RS_LSB = 17;
  localparam int unsigned RT_MSB = 16;
  localparam int unsigned RT_LSB = 12;

  localparam logic [OP_W-1:0] OPC_ALU  = OP_W'(0);
  localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(5);
  localparam logic [OP_W-1:0] OPC_SW   = OP_W'(7);
  localparam logic [OP_W-1:0] OPC_LW   = OP_W'(8);

  // Word loaded into D/X when a bubble is inserted
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage : proc_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the D/X instruction and the F/D instruction.
// Only rs is a true source for LW/ADDI/SW; rt is a source only for ALU ops.
// An SW store-data register (rd) is not compared: the M-stage bypass serves it.
module hazard_detect
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] dx_ir,
  input  logic              dx_valid,
  input  logic [DATA_W-1:0] fd_ir,
  output logic              hazard
);

  logic [OP_W-1:0]  w_dx_op;
  logic [REG_W-1:0] w_dx_rd;
  logic [OP_W-1:0]  w_fd_op;
  logic [REG_W-1:0] w_fd_rs;
  logic [REG_W-1:0] w_fd_rt;
  logic             w_unused_bits;

  assign w_dx_op = dx_ir[OP_MSB:OP_LSB];
  assign w_dx_rd = dx_ir[RD_MSB:RD_LSB];
  assign w_fd_op = fd_ir[OP_MSB:OP_LSB];
  assign w_fd_rs = fd_ir[RS_MSB:RS_LSB];
  assign w_fd_rt = fd_ir[RT_MSB:RT_LSB];

  // Fields that play no part in the compare
  assign w_unused_bits = ^{dx_ir[RS_MSB:0], fd_ir[RD_MSB:RD_LSB], fd_ir[RT_LSB-1:0]};

  // Hazard when a valid LW writing a nonzero register feeds a source of the F/D op
  always_comb begin
    hazard = 1'b0;
    if (dx_valid && (w_dx_op == OPC_LW) && (w_dx_rd != '0)) begin
      if (w_fd_rs == w_dx_rd) begin
        hazard = 1'b1;
      end else if ((w_fd_op == OPC_ALU) && (w_fd_rt == w_dx_rd)) begin
        hazard = 1'b1;
      end
    end
  end

endmodule : hazard_detect

// File: rtl/dx_stage_ctrl.sv
// D/X pipeline register with load-use bubble insertion, flush and a saturating
// load-use stall counter. Optional multdiv hold enabled by MULTDIV_STALL_EN.
module dx_stage_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] fd_ir,
  input  logic [DATA_W-1:0] fd_pc,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              flush,
`ifdef MULTDIV_STALL_EN
  input  logic              md_busy,
`endif
  output logic [DATA_W-1:0] dx_ir,
  output logic [DATA_W-1:0] dx_pc,
  output logic [DATA_W-1:0] dx_a,
  output logic [DATA_W-1:0] dx_b,
  output logic              dx_valid,
  output logic              stall_fd,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_dx_ir;
  logic [DATA_W-1:0] r_dx_pc;
  logic [DATA_W-1:0] r_dx_a;
  logic [DATA_W-1:0] r_dx_b;
  logic              r_dx_valid;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_hazard;
  logic w_md_hold_req;
  logic w_hold;
  logic w_bubble;
  logic w_kill;

  hazard_detect #(
    .DATA_W (DATA_W)
  ) u_hazard_detect (
    .dx_ir    (r_dx_ir),
    .dx_valid (r_dx_valid),
    .fd_ir    (fd_ir),
    .hazard   (w_hazard)
  );

`ifdef MULTDIV_STALL_EN
  assign w_md_hold_req = md_busy;
`else
  assign w_md_hold_req = 1'b0;
`endif

  // Priority: flush, then multdiv hold, then load-use bubble, else advance
  assign w_hold   = !flush && w_md_hold_req;
  assign w_bubble = !flush && !w_md_hold_req && w_hazard;
  assign w_kill   = flush || w_bubble;
  assign stall_fd = w_hold || w_bubble;

  // D/X pipeline register: bubble on flush or load-use, freeze on hold
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_dx_ir    <= '0;
      r_dx_pc    <= '0;
      r_dx_a     <= '0;
      r_dx_b     <= '0;
      r_dx_valid <= 1'b0;
    end else if (w_kill) begin
      r_dx_ir    <= DATA_W'(NOP_WORD);
      r_dx_pc    <= '0;
      r_dx_a     <= '0;
      r_dx_b     <= '0;
      r_dx_valid <= 1'b0;
    end else if (!w_hold) begin
      r_dx_ir    <= fd_ir;
      r_dx_pc    <= fd_pc;
      r_dx_a     <= rf_a;
      r_dx_b     <= rf_b;
      r_dx_valid <= 1'b1;
    end
  end

  // Saturating count of load-use bubbles only
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= '0;
    end else if (w_bubble && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign dx_ir       = r_dx_ir;
  assign dx_pc       = r_dx_pc;
  assign dx_a        = r_dx_a;
  assign dx_b        = r_dx_b;
  assign dx_valid    = r_dx_valid;
  assign stall_count = r_stall_count;

endmodule : dx_stage_ctrl

// File: tb/tb_dx_stage_ctrl.sv
// Self-checking bench for dx_stage_ctrl: directed scenarios plus random
// instruction streams compared against a behavioural pipeline model.
`timescale 1ns/1ps
module tb_dx_stage_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;
`ifdef MULTDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic              clock  = 1'b0;
  logic              resetn = 1'b0;
  logic [DATA_W-1:0] fd_ir, fd_pc, rf_a, rf_b;
  logic              flush;
  logic              md_busy;
  logic [DATA_W-1:0] dx_ir, dx_pc, dx_a, dx_b;
  logic              dx_valid;
  logic              stall_fd;
  logic [CNT_W-1:0]  stall_count;

  dx_stage_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .fd_ir       (fd_ir),
    .fd_pc       (fd_pc),
    .rf_a        (rf_a),
    .rf_b        (rf_b),
    .flush       (flush),
`ifdef MULTDIV_STALL_EN
    .md_busy     (md_busy),
`endif
    .dx_ir       (dx_ir),
    .dx_pc       (dx_pc),
    .dx_a        (dx_a),
    .dx_b        (dx_b),
    .dx_valid    (dx_valid),
    .stall_fd    (stall_fd),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] m_ir, m_pc, m_a, m_b;
  bit          m_valid;
  int          m_cnt;
  bit          last_stall;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt,
                                      input int imm);
    return 32'((op % 32) * (1 << 27) + (rd % 32) * (1 << 22) + (rs % 32) * (1 << 17)
               + (rt % 32) * (1 << 12) + (imm % 4096));
  endfunction

  function automatic logic [31:0] rand_instr();
    int sel;
    int op;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0:       op = 0;
      1:       op = 5;
      2:       op = 7;
      3, 4:    op = 8;
      default: op = int'($urandom_range(0, 31));
    endcase
    return enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
  endfunction

  // Load-use rule evaluated from instruction fields with plain arithmetic
  function automatic bit m_hazard(input logic [31:0] fd);
    int dop, drd, fop, frs, frt;
    dop = int'(m_ir / (1 << 27));
    drd = int'(m_ir / (1 << 22)) % 32;
    fop = int'(fd / (1 << 27));
    frs = int'(fd / (1 << 17)) % 32;
    frt = int'(fd / (1 << 12)) % 32;
    if (!m_valid || dop != 8 || drd == 0) return 1'b0;
    return (frs == drd) || (fop == 0 && frt == drd);
  endfunction

  task automatic model_clear();
    m_ir = 0; m_pc = 0; m_a = 0; m_b = 0; m_valid = 1'b0;
  endtask

  task automatic check_state(input string where);
    chk({where, ".dx_ir"}, 64'(dx_ir), 64'(m_ir));
    chk({where, ".dx_pc"}, 64'(dx_pc), 64'(m_pc));
    chk({where, ".dx_a"}, 64'(dx_a), 64'(m_a));
    chk({where, ".dx_b"}, 64'(dx_b), 64'(m_b));
    chk({where, ".dx_valid"}, 64'(dx_valid), 64'(m_valid));
    chk({where, ".stall_count"}, 64'(stall_count), 64'(m_cnt));
  endtask

  // One clock: drive at negedge, check stall_fd, advance model, check D/X
  task automatic cycle(input logic [31:0] ir, input logic [31:0] pc, input bit fl, input bit md);
    bit haz, md_eff, exp_stall;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    @(negedge clock);
    fd_ir = ir; fd_pc = pc; rf_a = a; rf_b = b; flush = fl; md_busy = md;
    #1;
    md_eff    = md_busy && MD_EN;
    haz       = m_hazard(ir);
    exp_stall = !fl && (md_eff || haz);
    last_stall = exp_stall;
    chk("stall_fd", 64'(stall_fd), 64'(exp_stall));
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else if (md_eff) begin
      // D/X frozen
    end else if (haz) begin
      model_clear();
      if (m_cnt < CNT_SAT) m_cnt++;
    end else begin
      m_ir = ir; m_pc = pc; m_a = a; m_b = b; m_valid = 1'b1;
    end
    #1;
    check_state("cyc");
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock
  task automatic reset_pulse(input string where);
    #1 resetn = 1'b0;
    #1;
    chk({where, ".ir0"}, 64'(dx_ir), 64'd0);
    chk({where, ".pc0"}, 64'(dx_pc), 64'd0);
    chk({where, ".a0"}, 64'(dx_a), 64'd0);
    chk({where, ".b0"}, 64'(dx_b), 64'd0);
    chk({where, ".valid0"}, 64'(dx_valid), 64'd0);
    chk({where, ".cnt0"}, 64'(stall_count), 64'd0);
    model_clear();
    m_cnt = 0;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lw_r3, add_r4, sw_r3, lw_r0, add_r0, cur_ir, cur_pc;
    fd_ir = '0; fd_pc = '0; rf_a = '0; rf_b = '0; flush = 1'b0; md_busy = 1'b0;
    model_clear();
    m_cnt = 0;
    last_stall = 1'b0;

    lw_r3  = enc(8, 3, 1, 0, 0);
    add_r4 = enc(0, 4, 3, 2, 0);
    sw_r3  = enc(7, 3, 5, 0, 0);
    lw_r0  = enc(8, 0, 1, 0, 0);
    add_r0 = enc(0, 4, 0, 0, 0);

    #12;
    chk("reset.dx_ir", 64'(dx_ir), 64'd0);
    chk("reset.dx_valid", 64'(dx_valid), 64'd0);
    chk("reset.stall_count", 64'(stall_count), 64'd0);
    #1 resetn = 1'b1;

    // lw r3 then dependent add: one bubble, then add advances
    cycle(lw_r3, 32'h100, 1'b0, 1'b0);
    chk("lu.lw_in_dx", 64'(dx_ir), 64'(lw_r3));
    cycle(add_r4, 32'h104, 1'b0, 1'b0);
    chk("lu.bubble_valid", 64'(dx_valid), 64'd0);
    chk("lu.bubble_ir", 64'(dx_ir), 64'd0);
    chk("lu.count1", 64'(stall_count), 64'd1);
    cycle(add_r4, 32'h104, 1'b0, 1'b0);
    chk("lu.add_in_dx", 64'(dx_ir), 64'(add_r4));

    // lw r3 then sw r3: store data bypassed, no stall
    cycle(lw_r3, 32'h108, 1'b0, 1'b0);
    cycle(sw_r3, 32'h10c, 1'b0, 1'b0);
    chk("sw.in_dx", 64'(dx_ir), 64'(sw_r3));
    chk("sw.count", 64'(stall_count), 64'd1);

    // lw r0 never causes a stall
    cycle(lw_r0, 32'h110, 1'b0, 1'b0);
    cycle(add_r0, 32'h114, 1'b0, 1'b0);
    chk("r0.add_in_dx", 64'(dx_ir), 64'(add_r0));
    chk("r0.valid", 64'(dx_valid), 64'd1);

    // Hazard plus flush: bubble, no stall, no count
    cycle(lw_r3, 32'h118, 1'b0, 1'b0);
    cycle(add_r4, 32'h11c, 1'b1, 1'b0);
    chk("fl.valid", 64'(dx_valid), 64'd0);
    chk("fl.count", 64'(stall_count), 64'd1);

    // Repeated load-use events saturate the counter
    for (int k = 0; k < 20; k++) begin
      cycle(lw_r3, 32'h200, 1'b0, 1'b0);
      cycle(add_r4, 32'h204, 1'b0, 1'b0);
      cycle(add_r4, 32'h204, 1'b0, 1'b0);
    end
    chk("sat.count", 64'(stall_count), 64'(CNT_SAT));

`ifdef MULTDIV_STALL_EN
    // Multdiv busy freezes D/X and stalls fetch, without counting
    begin
      logic [31:0] mul_i;
      mul_i = enc(0, 6, 1, 2, 12);
      cycle(mul_i, 32'h300, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        cycle(enc(0, 7, 6, 6, 0), 32'h304, 1'b0, 1'b1);
        chk("md.hold_ir", 64'(dx_ir), 64'(mul_i));
        chk("md.count", 64'(stall_count), 64'(CNT_SAT));
      end
      reset_pulse("md_rst");
    end
`endif

    // Reset during a load-use stall; first edge afterwards advances normally
    cycle(lw_r3, 32'h400, 1'b0, 1'b0);
    cycle(add_r4, 32'h404, 1'b0, 1'b0);
    reset_pulse("rst_stall");
    cycle(add_r4, 32'h404, 1'b0, 1'b0);
    chk("rst_stall.adv_ir", 64'(dx_ir), 64'(add_r4));
    chk("rst_stall.adv_valid", 64'(dx_valid), 64'd1);

    // Random stream; F/D holds its instruction while stalled
    cur_ir = rand_instr();
    cur_pc = $urandom;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        cur_ir = rand_instr();
        cur_pc = $urandom;
      end
      cycle(cur_ir, cur_pc, ($urandom % 8) == 0, ($urandom % 6) == 0);
    end

    reset_pulse("rnd_rst");
    for (int i = 0; i < 100; i++) begin
      if (!last_stall) begin
        cur_ir = rand_instr();
        cur_pc = $urandom;
      end
      cycle(cur_ir, cur_pc, ($urandom % 10) == 0, ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dx_stage_ctrl
